// File: rtl/cwt_res_reader.sv
// cwt_res_reader
// Drains one CWT result frame (real + imaginary banks, N*J1 words each) out of
// the result BRAMs and streams it to a valid/ready consumer, tagging every beat
// with its scale index j and sample index n. The CWT core is held off through
// busy_o until every coefficient of the frame has been accepted downstream.
//
// Ports
//   clk, rst          : single rising-edge clock, asynchronous active-high reset
//   cwt_done_i        : frame-stored pulse from the CWT core, starts a drain
//   busy_o            : high while a frame is being drained
//   bram_en_o         : read enable shared by both result banks
//   bram_addr_o       : read address j*N + n
//   bram_re_i/im_i    : read data, valid one cycle after the enable
//   m_valid_o/ready_i : output handshake
//   m_re_o, m_im_o    : coefficient data (passed through unmodified)
//   m_scale_o/idx_o   : j and n of the current beat
//   m_last_scale_o    : n = N-1
//   m_last_frame_o    : j = J1-1 and n = N-1
//   done_o            : one-cycle pulse after the final beat is accepted
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for cwt_done_i
// READ  | issuing reads 0 .. N*J1-1, throttled by FIFO space
// DRAIN | all reads issued; waiting for FIFO and read pipe to empty

module cwt_res_reader #(
   parameter int N  = 1024,
   parameter int J1 = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cwt_done_i,
   output logic                      busy_o,
   output logic                      bram_en_o,
   output logic [$clog2(N*J1)-1:0]   bram_addr_o,
   input  logic [31:0]               bram_re_i,
   input  logic [31:0]               bram_im_i,
   output logic                      m_valid_o,
   input  logic                      m_ready_i,
   output logic [31:0]               m_re_o,
   output logic [31:0]               m_im_o,
   output logic [$clog2(J1)-1:0]     m_scale_o,
   output logic [$clog2(N)-1:0]      m_idx_o,
   output logic                      m_last_scale_o,
   output logic                      m_last_frame_o,
   output logic                      done_o
);

   localparam int AW = $clog2(N*J1);
   localparam int NW = $clog2(N);
   localparam int JW = $clog2(J1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(N*J1-1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [AW-1:0] issue_cnt;
   logic          issue;
   logic          pop;

   // read pipe: a read issued in one cycle has its data on the bus the next
   logic          pend;
   logic [AW-1:0] pend_addr;

   // two-entry output FIFO, enough to cover the one-cycle read latency at
   // full rate
   logic [31:0]   fifo_re    [2];
   logic [31:0]   fifo_im    [2];
   logic [JW-1:0] fifo_scale [2];
   logic [NW-1:0] fifo_idx   [2];
   logic          fifo_ls    [2];
   logic          fifo_lf    [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    fifo_cnt;
   logic [2:0]    outstanding;

   assign outstanding = {1'b0, fifo_cnt} + {2'b00, pend};
   assign pop         = (fifo_cnt != 2'd0) && m_ready_i;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cwt_done_i) begin
               state_nxt = S_READ;
            end
         end
         S_READ: begin
            if (issue && (issue_cnt == LAST_ADDR)) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((fifo_cnt == 2'd0) && !pend) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // output logic; a pop in the same cycle frees the slot the new read needs,
   // which is what keeps a ready-high stream at one beat per clock
   always_comb begin
      issue          = (state == S_READ) && ((outstanding < 3'd2) || pop);
      bram_en_o      = issue;
      bram_addr_o    = issue_cnt;
      m_valid_o      = (fifo_cnt != 2'd0);
      m_re_o         = fifo_re[rd_ptr];
      m_im_o         = fifo_im[rd_ptr];
      m_scale_o      = fifo_scale[rd_ptr];
      m_idx_o        = fifo_idx[rd_ptr];
      m_last_scale_o = fifo_ls[rd_ptr];
      m_last_frame_o = fifo_lf[rd_ptr];
   end

   // issue counter stops on the final address so the address bus keeps
   // showing it until the next frame starts
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt <= '0;
      end else if ((state == S_IDLE) && cwt_done_i) begin
         issue_cnt <= '0;
      end else if (issue && (issue_cnt != LAST_ADDR)) begin
         issue_cnt <= issue_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend      <= 1'b0;
         pend_addr <= '0;
      end else begin
         pend <= issue;
         if (issue) begin
            pend_addr <= issue_cnt;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         busy_o <= (state_nxt != S_IDLE);
         done_o <= (state == S_DRAIN) && (state_nxt == S_IDLE);
      end
   end

   // FIFO storage is cleared on reset so every m_* output reads 0 right away
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            fifo_re[i]    <= '0;
            fifo_im[i]    <= '0;
            fifo_scale[i] <= '0;
            fifo_idx[i]   <= '0;
            fifo_ls[i]    <= 1'b0;
            fifo_lf[i]    <= 1'b0;
         end
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (pend) begin
            fifo_re[wr_ptr]    <= bram_re_i;
            fifo_im[wr_ptr]    <= bram_im_i;
            fifo_scale[wr_ptr] <= pend_addr[AW-1:NW];
            fifo_idx[wr_ptr]   <= pend_addr[NW-1:0];
            fifo_ls[wr_ptr]    <= &pend_addr[NW-1:0];
            fifo_lf[wr_ptr]    <= &pend_addr;
            wr_ptr             <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         fifo_cnt <= fifo_cnt + {1'b0, pend} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_cwt_res_reader.sv
module tb_cwt_res_reader;

   localparam int N  = 8;
   localparam int J1 = 4;
   localparam int NJ = N * J1;
   localparam int AW = $clog2(NJ);
   localparam int NW = $clog2(N);
   localparam int JW = $clog2(J1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cwt_done_i = 1'b0;
   logic          busy_o;
   logic          bram_en_o;
   logic [AW-1:0] bram_addr_o;
   logic [31:0]   bram_re_i = '0;
   logic [31:0]   bram_im_i = '0;
   logic          m_valid_o;
   logic          m_ready_i = 1'b0;
   logic [31:0]   m_re_o;
   logic [31:0]   m_im_o;
   logic [JW-1:0] m_scale_o;
   logic [NW-1:0] m_idx_o;
   logic          m_last_scale_o;
   logic          m_last_frame_o;
   logic          done_o;

   cwt_res_reader #(.N(N), .J1(J1)) dut (
      .clk            (clk),
      .rst            (rst),
      .cwt_done_i     (cwt_done_i),
      .busy_o         (busy_o),
      .bram_en_o      (bram_en_o),
      .bram_addr_o    (bram_addr_o),
      .bram_re_i      (bram_re_i),
      .bram_im_i      (bram_im_i),
      .m_valid_o      (m_valid_o),
      .m_ready_i      (m_ready_i),
      .m_re_o         (m_re_o),
      .m_im_o         (m_im_o),
      .m_scale_o      (m_scale_o),
      .m_idx_o        (m_idx_o),
      .m_last_scale_o (m_last_scale_o),
      .m_last_frame_o (m_last_frame_o),
      .done_o         (done_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]   re;
      logic [31:0]   im;
      logic [JW-1:0] scale;
      logic [NW-1:0] idx;
      logic          ls;
      logic          lf;
   } beat_t;

   // BRAM contents: real word = salt ^ address, imaginary = its complement
   logic [31:0] salt = '0;
   always @(posedge clk) begin
      if (bram_en_o) begin
         bram_re_i <= salt ^ {{(32-AW){1'b0}}, bram_addr_o};
         bram_im_i <= ~(salt ^ {{(32-AW){1'b0}}, bram_addr_o});
      end
   end

   int    cyc = 0;
   int    n_checks = 0;
   int    n_errors = 0;
   beat_t beats[$];
   int    bcyc[$];
   int    dcyc[$];
   int    busy_fall = -1;
   logic  busy_prev = 1'b0;

   always @(posedge clk) cyc++;

   // accepted-beat and done-pulse recorder, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid_o && m_ready_i) begin
            beats.push_back('{re: m_re_o, im: m_im_o, scale: m_scale_o, idx: m_idx_o,
                              ls: m_last_scale_o, lf: m_last_frame_o});
            bcyc.push_back(cyc);
         end
         if (done_o) dcyc.push_back(cyc);
         if (busy_prev && !busy_o) busy_fall = cyc;
      end
      busy_prev = busy_o;
   end

   // reference: coefficient at address a of a frame whose BRAM holds salt s
   function automatic beat_t model_beat(input logic [31:0] s, input int a);
      beat_t b;
      b.re    = s ^ 32'(a);
      b.im    = ~(s ^ 32'(a));
      b.scale = JW'(a / N);
      b.idx   = NW'(a % N);
      b.ls    = ((a % N) == N - 1);
      b.lf    = (a == NJ - 1);
      return b;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      beats.delete();
      bcyc.delete();
      dcyc.delete();
      busy_fall = -1;
   endtask

   // returns the edge at which cwt_done_i is sampled
   task automatic start_frame(input logic [31:0] s, output int k);
      salt       = s;
      cwt_done_i = 1'b1;
      k          = cyc + 1;
      step();
      cwt_done_i = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget, output bit ok);
      int i;
      i = 0;
      while (dcyc.size() < n && i < budget) begin
         step();
         i++;
      end
      ok = (dcyc.size() >= n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      n_checks++;
      if ({busy_o, done_o, bram_en_o, bram_addr_o, m_valid_o, m_last_scale_o, m_last_frame_o} !== '0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %b required 0",
                  {busy_o, done_o, bram_en_o, bram_addr_o, m_valid_o, m_last_scale_o, m_last_frame_o});
      end
      n_checks++;
      if ({m_re_o, m_im_o, m_scale_o, m_idx_o} !== '0) begin
         n_errors++;
         $display("FAIL reset_data: got %h required 0", {m_re_o, m_im_o, m_scale_o, m_idx_o});
      end
      rst = 1'b0;
      repeat (5) step();
      n_checks++;
      if (beats.size() != 0 || busy_o !== 1'b0 || bram_en_o !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_idle: beats %0d busy %b en %b required 0 0 0", beats.size(), busy_o, bram_en_o);
      end
   endtask

   task automatic test_stream();
      int k;
      bit ok;
      clear_log();
      m_ready_i = 1'b1;
      start_frame(32'h0, k);
      wait_done(1, 100, ok);
      repeat (5) step();
      n_checks++;
      if (!ok || beats.size() != NJ) begin
         n_errors++;
         $display("FAIL stream_count: got %0d beats required %0d (done seen %0b)", beats.size(), NJ, ok);
      end
      for (int i = 0; i < NJ && i < beats.size(); i++) begin
         n_checks++;
         if (beats[i] !== model_beat(32'h0, i) || bcyc[i] != k + 2 + i) begin
            n_errors++;
            $display("FAIL stream_beat[%0d]: got %h at cycle %0d required %h at cycle %0d",
                     i, beats[i], bcyc[i], model_beat(32'h0, i), k + 2 + i);
         end
      end
      n_checks++;
      if (dcyc.size() != 1 || dcyc[0] != k + NJ + 3) begin
         n_errors++;
         $display("FAIL stream_done: got %0d pulses first at %0d required 1 at %0d",
                  dcyc.size(), (dcyc.size() > 0) ? dcyc[0] : -1, k + NJ + 3);
      end
      n_checks++;
      if (busy_fall != k + NJ + 3) begin
         n_errors++;
         $display("FAIL stream_busy_fall: got cycle %0d required %0d", busy_fall, k + NJ + 3);
      end
   endtask

   task automatic test_stall();
      int          k, stall, guard;
      bit          stalled;
      logic [31:0] s;
      s = $urandom;
      clear_log();
      m_ready_i = 1'b1;
      stalled = 1'b0;
      stall = 0;
      guard = 0;
      start_frame(s, k);
      while (dcyc.size() < 1 && guard < 200) begin
         step();
         guard++;
         if (!stalled && beats.size() == 5) begin
            stalled = 1'b1;
            stall   = 10;
         end
         if (stall > 0) begin
            m_ready_i = 1'b0;
            #1;
            n_checks++;
            if (m_valid_o !== 1'b1 || m_re_o !== model_beat(s, 5).re || bram_en_o !== 1'b0) begin
               n_errors++;
               $display("FAIL stall_hold[%0d]: valid %b re %h en %b required 1 %h 0",
                        10 - stall, m_valid_o, m_re_o, bram_en_o, model_beat(s, 5).re);
            end
            stall--;
         end else begin
            m_ready_i = 1'b1;
         end
      end
      n_checks++;
      if (beats.size() != NJ || dcyc.size() != 1) begin
         n_errors++;
         $display("FAIL stall_count: got %0d beats %0d dones required %0d 1", beats.size(), dcyc.size(), NJ);
      end
      for (int i = 0; i < NJ && i < beats.size(); i++) begin
         n_checks++;
         if (beats[i] !== model_beat(s, i)) begin
            n_errors++;
            $display("FAIL stall_beat[%0d]: got %h required %h", i, beats[i], model_beat(s, i));
         end
      end
      if (beats.size() == NJ) begin
         n_checks++;
         if (bcyc[5] - bcyc[4] != 11) begin
            n_errors++;
            $display("FAIL stall_gap: got %0d cycles between beats 4 and 5 required 11", bcyc[5] - bcyc[4]);
         end
         for (int i = 6; i < NJ; i++) begin
            n_checks++;
            if (bcyc[i] != bcyc[i-1] + 1) begin
               n_errors++;
               $display("FAIL stall_resume[%0d]: got spacing %0d required 1", i, bcyc[i] - bcyc[i-1]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] salts[3];
      int          started, guard;
      clear_log();
      foreach (salts[f]) salts[f] = $urandom;
      salt       = salts[0];
      cwt_done_i = 1'b1;
      started    = 1;
      guard      = 0;
      while (dcyc.size() < 3 && guard < 2000) begin
         step();
         guard++;
         cwt_done_i = 1'b0;
         m_ready_i  = ($urandom_range(1, 0) == 1);
         if (done_o && started < 3) begin
            salt       = salts[started];
            cwt_done_i = 1'b1;
            started++;
         end
      end
      m_ready_i = 1'b1;
      repeat (5) step();
      n_checks++;
      if (beats.size() != 3 * NJ || dcyc.size() != 3) begin
         n_errors++;
         $display("FAIL random_count: got %0d beats %0d dones required %0d 3", beats.size(), dcyc.size(), 3 * NJ);
      end
      for (int i = 0; i < 3 * NJ && i < beats.size(); i++) begin
         n_checks++;
         if (beats[i] !== model_beat(salts[i / NJ], i % NJ)) begin
            n_errors++;
            $display("FAIL random_beat[%0d]: got %h required %h", i, beats[i], model_beat(salts[i / NJ], i % NJ));
         end
      end
   endtask

   task automatic test_back_to_back();
      int          k1, k2, guard;
      bit          second;
      logic [31:0] s1, s2;
      s1 = $urandom;
      s2 = $urandom;
      clear_log();
      m_ready_i = 1'b1;
      second = 1'b0;
      k2 = -1;
      guard = 0;
      start_frame(s1, k1);
      while (dcyc.size() < 2 && guard < 300) begin
         step();
         guard++;
         cwt_done_i = 1'b0;
         if (done_o && !second) begin
            second     = 1'b1;
            salt       = s2;
            cwt_done_i = 1'b1;
            k2         = cyc + 1;
         end
      end
      n_checks++;
      if (beats.size() != 2 * NJ || dcyc.size() != 2) begin
         n_errors++;
         $display("FAIL b2b_count: got %0d beats %0d dones required %0d 2", beats.size(), dcyc.size(), 2 * NJ);
      end
      n_checks++;
      if (dcyc.size() < 1 || dcyc[0] != k1 + NJ + 3 || k2 != dcyc[0] + 1) begin
         n_errors++;
         $display("FAIL b2b_first_done: got done at %0d restart edge %0d required %0d %0d",
                  (dcyc.size() > 0) ? dcyc[0] : -1, k2, k1 + NJ + 3, k1 + NJ + 4);
      end
      if (beats.size() == 2 * NJ) begin
         n_checks++;
         if (bcyc[NJ] != k2 + 2) begin
            n_errors++;
            $display("FAIL b2b_second_start: got first beat at %0d required %0d", bcyc[NJ], k2 + 2);
         end
         for (int i = 0; i < 2 * NJ; i++) begin
            n_checks++;
            if (beats[i] !== model_beat((i < NJ) ? s1 : s2, i % NJ)) begin
               n_errors++;
               $display("FAIL b2b_beat[%0d]: got %h required %h", i, beats[i], model_beat((i < NJ) ? s1 : s2, i % NJ));
            end
         end
      end
   endtask

   task automatic test_ignore_done();
      int          k, guard;
      bit          p1, p2, ok;
      logic [31:0] s;
      s = $urandom;
      clear_log();
      m_ready_i = 1'b1;
      p1 = 1'b0;
      p2 = 1'b0;
      guard = 0;
      start_frame(s, k);
      while (dcyc.size() < 1 && guard < 200) begin
         step();
         guard++;
         cwt_done_i = 1'b0;
         if (beats.size() == 10 && !p1) begin
            p1 = 1'b1;
            cwt_done_i = 1'b1;
         end
         if (beats.size() == NJ && !p2) begin
            p2 = 1'b1;
            cwt_done_i = 1'b1;
         end
      end
      cwt_done_i = 1'b0;
      ok = (dcyc.size() == 1);
      repeat (40) step();
      n_checks++;
      if (!ok || !p2 || beats.size() != NJ || dcyc.size() != 1 || busy_o !== 1'b0) begin
         n_errors++;
         $display("FAIL ignore_count: got %0d beats %0d dones busy %b required %0d 1 0",
                  beats.size(), dcyc.size(), busy_o, NJ);
      end
      for (int i = 0; i < NJ && i < beats.size(); i++) begin
         n_checks++;
         if (beats[i] !== model_beat(s, i)) begin
            n_errors++;
            $display("FAIL ignore_beat[%0d]: got %h required %h", i, beats[i], model_beat(s, i));
         end
      end
   endtask

   task automatic test_reset_mid();
      int          k, guard;
      bit          ok;
      logic [31:0] s1, s2;
      s1 = $urandom;
      s2 = ~s1;
      clear_log();
      m_ready_i = 1'b1;
      guard = 0;
      start_frame(s1, k);
      while (beats.size() < 12 && guard < 100) begin
         step();
         guard++;
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy_o, done_o, bram_en_o, bram_addr_o, m_valid_o, m_last_scale_o, m_last_frame_o} !== '0) begin
         n_errors++;
         $display("FAIL midrst_ctrl: got %b required 0",
                  {busy_o, done_o, bram_en_o, bram_addr_o, m_valid_o, m_last_scale_o, m_last_frame_o});
      end
      n_checks++;
      if ({m_re_o, m_im_o, m_scale_o, m_idx_o} !== '0) begin
         n_errors++;
         $display("FAIL midrst_data: got %h required 0", {m_re_o, m_im_o, m_scale_o, m_idx_o});
      end
      step();
      step();
      rst = 1'b0;
      repeat (6) step();
      n_checks++;
      if (beats.size() != 12 || m_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_idle: beats %0d valid %b busy %b required 12 0 0", beats.size(), m_valid_o, busy_o);
      end
      clear_log();
      start_frame(s2, k);
      wait_done(1, 100, ok);
      n_checks++;
      if (!ok || beats.size() != NJ) begin
         n_errors++;
         $display("FAIL midrst_restart_count: got %0d beats required %0d", beats.size(), NJ);
      end
      n_checks++;
      if (beats.size() < 1 || bcyc[0] != k + 2) begin
         n_errors++;
         $display("FAIL midrst_restart_time: got first beat at %0d required %0d",
                  (bcyc.size() > 0) ? bcyc[0] : -1, k + 2);
      end
      for (int i = 0; i < NJ && i < beats.size(); i++) begin
         n_checks++;
         if (beats[i] !== model_beat(s2, i)) begin
            n_errors++;
            $display("FAIL midrst_beat[%0d]: got %h required %h", i, beats[i], model_beat(s2, i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      repeat (3) step();
      test_stall();
      repeat (3) step();
      test_random();
      repeat (3) step();
      test_back_to_back();
      repeat (3) step();
      test_ignore_done();
      repeat (3) step();
      test_reset_mid();
      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cwt_res_reader.md
# cwt_res_reader

Read-side engine for the CWT result memories (real and imaginary banks of N·J1 words each). After the CWT core signals that a frame is complete, this block reads every coefficient in storage order and streams it to the downstream consumer over a valid/ready interface. Each beat is tagged with its scale and sample index. The block holds the CWT core off through `busy_o` until the whole frame has been drained.

## Interface
- `N`, 1024: samples per scale (power of two).
- `J1`, 64: number of scales (power of two).
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `cwt_done_i` in 1: one-cycle pulse meaning a full frame is stored and reading may start.
- `busy_o` out 1: high while a frame is being drained; drives the CWT core's downstream-busy input.
- `bram_en_o` out 1: result-BRAM read enable, shared by both banks; write enable is never driven.
- `bram_addr_o` out $clog2(N*J1): read address, equal to j·N + n.
- `bram_re_i` in 32: real read data, valid 1 cycle after the enable.
- `bram_im_i` in 32: imaginary read data, same timing.
- `m_valid_o` out 1: output beat valid.
- `m_ready_i` in 1: consumer ready.
- `m_re_o`, `m_im_o` out 32 each: coefficient data.
- `m_scale_o` out $clog2(J1): scale index j.
- `m_idx_o` out $clog2(N): sample index n.
- `m_last_scale_o` out 1: high when n = N-1.
- `m_last_frame_o` out 1: high when j = J1-1 and n = N-1.
- `done_o` out 1: one-cycle pulse after the final beat is accepted.

## Operation
- Reset values: every output is 0, the FSM is in IDLE, and all counters, FIFO contents and in-flight flags are cleared.
- FSM states:
  - IDLE: `cwt_done_i`=1 moves to READ and sets the issue counter to 0.
  - READ: issues reads. After address N·J1-1 has been issued, moves to DRAIN.
  - DRAIN: waits for the FIFO to empty and no read to be in flight, then moves to IDLE and pulses `done_o`.
- `busy_o` = (state ≠ IDLE), registered.
- Read issue:
  - A read is issued in a cycle only when the state is READ and (fifo_count + inflight < 2, or a pop happens this cycle).
  - An issued read drives `bram_en_o`=1 and `bram_addr_o` = issue counter; the issue counter then increments.
  - When no read is issued, `bram_addr_o` holds its last value.
- Capture: read data returns exactly 1 cycle after issue and is written into a 2-entry FIFO together with its j, n and last flags, derived from the issued address.
- Output:
  - `m_valid_o` = FIFO not empty; the `m_*` outputs come from the FIFO head.
  - A pop happens when `m_valid_o` and `m_ready_i` are both high.
  - While `m_valid_o`=1 and `m_ready_i`=0, all `m_*` outputs are held stable.
- Ordering: beats leave in address order 0 … N·J1-1, scale-major, matching the CWT store order. No beat is lost or duplicated.
- Counter wrap: the issue counter is $clog2(N*J1) bits. Its final value N·J1-1 triggers the move to DRAIN, and it never wraps within a frame.
- `cwt_done_i` while `busy_o`=1 is ignored. This includes the DRAIN cycle in which the FIFO becomes empty.
- `cwt_done_i` coincident with `done_o` (state already IDLE) is accepted and starts a new frame.
- Reset mid-frame clears the FIFO and discards any in-flight read data. After release, the block waits in IDLE for a fresh `cwt_done_i`.
- Data is passed through unmodified; the block does no arithmetic on it.

## Timing
- `cwt_done_i` sampled at edge k:
  - `bram_en_o`=1 with address 0 during cycle k → k+1.
  - Data is captured at edge k+2, and `m_valid_o` rises after edge k+2.
- With `m_ready_i` held high, the block sustains 1 beat per clock. A frame with ready held high drains in N·J1 consecutive beats.
- Backpressure:
  - Once the FIFO plus in-flight reads total 2, `bram_en_o` stays low until a pop.
  - After `m_ready_i` rises again, the next beat is presented on the same edge at which the held beat pops, so there are no bubbles.
- Final beat accepted at edge t:
  - State is IDLE after edge t+1.
  - `busy_o`=0 after edge t+1.
  - `done_o`=1 during cycle t+1 → t+2.

## Test plan
- N=8, J1=4, `m_ready_i`=1, `cwt_done_i` at edge 0, BRAM model returning re = addr and im = ~addr:
  - 32 beats on consecutive cycles starting after edge 2, with re values 0..31.
  - `m_last_scale_o` on beats 7, 15, 23, 31; `m_last_frame_o` only on beat 31.
  - `done_o` pulses once and `busy_o` falls one cycle after beat 31.
- Same setup with `m_ready_i` low for 10 cycles starting at beat 5:
  - `m_re_o`=5 is held throughout the stall.
  - `bram_en_o` is low for the stall after at most 2 outstanding reads.
  - Beats 6..31 follow with no gaps, duplicates or losses.
- Random `m_ready_i` (50% duty) over 3 back-to-back frames: scoreboard shows exact order, 96 beats, 3 `done_o` pulses.
- `cwt_done_i` pulsed at beat 10 of a frame: ignored, and the frame still ends after exactly 32 beats.
- `rst` asserted at beat 12:
  - All outputs are 0 immediately, asynchronously.
  - A later `cwt_done_i` restarts from address 0 with no stale beat.
- `cwt_done_i` in the same cycle as `done_o`: the second frame starts, and its first beat appears 2 edges later.
